// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared court constants, serve angles and rule-engine state encoding.
package pong_pkg;
  localparam int COURT_SIZE = 64;
  localparam int COURT_MAX  = COURT_SIZE - 1;

  localparam logic [3:0] ANG_RIGHT = 4'd0;
  localparam logic [3:0] ANG_LEFT  = 4'd12;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;
endpackage

// File: rtl/court_ctrl_if.sv
// rtl/court_ctrl_if.sv - ball/paddle inputs and ball-mover/score outputs of court_ctrl.
interface court_ctrl_if;
  logic       tick;
  logic [5:0] ball_x;
  logic [5:0] ball_y;
  logic [3:0] ball_radius;
  logic [5:0] paddle_l_y;
  logic [5:0] paddle_r_y;
  logic       flip_x;
  logic       flip_y;
  logic [3:0] angle;
  logic       ball_reset;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner;

  modport master (
    output tick, ball_x, ball_y, ball_radius, paddle_l_y, paddle_r_y,
    input  flip_x, flip_y, angle, ball_reset, score_l, score_r, game_over, winner
  );

  modport slave (
    input  tick, ball_x, ball_y, ball_radius, paddle_l_y, paddle_r_y,
    output flip_x, flip_y, angle, ball_reset, score_l, score_r, game_over, winner
  );
endinterface

// File: rtl/paddle_hit.sv
// rtl/paddle_hit.sv - combinational hit/edge/zone/goal compare for one paddle face.
module paddle_hit
  import pong_pkg::*;
#(
  parameter int FACE_X     = 2,
  parameter bit RIGHT_SIDE = 1'b0,
  parameter int PADDLE_H   = 8
) (
  input  logic [5:0] i_ball_x,
  input  logic [5:0] i_ball_y,
  input  logic [3:0] i_ball_radius,
  input  logic [5:0] i_paddle_y,
  output logic       o_hit,
  output logic       o_edge,
  output logic       o_outer,
  output logic       o_miss
);
  localparam int QUARTER = PADDLE_H / 4;

  logic [7:0] w_bx;
  logic [7:0] w_by;
  logic [7:0] w_r;
  logic [7:0] w_top;
  logic [7:0] w_bot_raw;
  logic [7:0] w_bot;
  logic [7:0] w_ofs;
  logic       w_in_x;
  logic       w_in_y;

  // 8-bit widening keeps face +/- radius and paddle bottom from wrapping
  assign w_bx      = {2'b00, i_ball_x};
  assign w_by      = {2'b00, i_ball_y};
  assign w_r       = {4'b0000, i_ball_radius};
  assign w_top     = {2'b00, i_paddle_y};
  assign w_bot_raw = w_top + 8'(PADDLE_H - 1);
  assign w_bot     = (w_bot_raw > 8'(COURT_MAX)) ? 8'(COURT_MAX) : w_bot_raw;
  assign w_ofs     = w_by - w_top;

  generate
    if (RIGHT_SIDE) begin : g_right
      assign w_in_x = w_bx >= (8'(FACE_X - 1) - w_r);
      assign o_miss = w_bx >= (8'(COURT_MAX) - w_r);
    end else begin : g_left
      assign w_in_x = w_bx <= (8'(FACE_X + 1) + w_r);
      assign o_miss = w_bx <= w_r;
    end
  endgenerate

  assign w_in_y  = (w_by >= w_top) && (w_by <= w_bot);
  assign o_hit   = w_in_x && w_in_y;
  assign o_edge  = (w_by == w_top) || (w_by == w_bot_raw);
  assign o_outer = (w_ofs < 8'(QUARTER)) || (w_ofs >= 8'(PADDLE_H - QUARTER));
endmodule

// File: rtl/court_ctrl.sv
// rtl/court_ctrl.sv - pong rule engine: hits, misses, score, serve/play/over sequencing.
// Optional COURT_PADDLE_ANGLE_EN: paddle zone loads angle instead of pulsing flip_x.
module court_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_H    = 8,
  parameter int LEFT_X      = 2,
  parameter int RIGHT_X     = 61,
  parameter int HOLD_CYCLES = 4,
  parameter int SERVE_TICKS = 16,
  parameter int WIN_SCORE   = 9
) (
  input  logic         clk,
  input  logic         reset,
  court_ctrl_if.slave  bus
);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_serve_cnt;
  logic [7:0] r_hold;
  logic       r_flip_x;
  logic       r_flip_y;
  logic [3:0] r_angle;
  logic       r_ball_reset;
  logic [3:0] r_score_l;
  logic [3:0] r_score_r;
  logic       r_game_over;
  logic       r_winner;

  logic       w_l_hit, w_l_edge, w_l_outer, w_l_goal;
  logic       w_r_hit, w_r_edge, w_r_outer, w_r_goal;
  logic       w_play;
  logic       w_acc_l;
  logic       w_acc_r;
  logic       w_acc;
  logic       w_miss_l;
  logic       w_miss_r;
  logic [3:0] w_score_l_inc;
  logic [3:0] w_score_r_inc;
  logic       w_ball_reset_nxt;
  logic       w_game_over_nxt;

  paddle_hit #(.FACE_X(LEFT_X), .RIGHT_SIDE(1'b0), .PADDLE_H(PADDLE_H)) u_hit_l (
    .i_ball_x      (bus.ball_x),
    .i_ball_y      (bus.ball_y),
    .i_ball_radius (bus.ball_radius),
    .i_paddle_y    (bus.paddle_l_y),
    .o_hit         (w_l_hit),
    .o_edge        (w_l_edge),
    .o_outer       (w_l_outer),
    .o_miss        (w_l_goal)
  );

  paddle_hit #(.FACE_X(RIGHT_X), .RIGHT_SIDE(1'b1), .PADDLE_H(PADDLE_H)) u_hit_r (
    .i_ball_x      (bus.ball_x),
    .i_ball_y      (bus.ball_y),
    .i_ball_radius (bus.ball_radius),
    .i_paddle_y    (bus.paddle_r_y),
    .o_hit         (w_r_hit),
    .o_edge        (w_r_edge),
    .o_outer       (w_r_outer),
    .o_miss        (w_r_goal)
  );

  assign w_play  = (r_state == ST_PLAY);
  assign w_acc_l = w_play && (r_hold == 8'd0) && w_l_hit;
  assign w_acc_r = w_play && (r_hold == 8'd0) && w_r_hit && !w_l_hit;
  assign w_acc   = w_acc_l || w_acc_r;

  // Any raw hit, even one masked by the hold window, cancels a point that cycle
  assign w_miss_l = w_play && w_l_goal && !w_l_hit && !w_r_hit;
  assign w_miss_r = w_play && w_r_goal && !w_r_hit && !w_l_hit && !w_miss_l;

  assign w_score_l_inc = r_score_l + 4'd1;
  assign w_score_r_inc = r_score_r + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_SERVE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SERVE: if (bus.tick && (r_serve_cnt == SERVE_LAST)) w_state_next = ST_PLAY;
      ST_PLAY: begin
        if (w_miss_l)      w_state_next = (w_score_r_inc == WIN) ? ST_OVER : ST_SERVE;
        else if (w_miss_r) w_state_next = (w_score_l_inc == WIN) ? ST_OVER : ST_SERVE;
      end
      ST_OVER:  w_state_next = ST_OVER;
      default:  w_state_next = ST_SERVE;
    endcase
  end

  always_comb begin
    w_ball_reset_nxt = (w_state_next != ST_PLAY);
    w_game_over_nxt  = (w_state_next == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_serve_cnt  <= 8'd0;
      r_hold       <= 8'd0;
      r_flip_x     <= 1'b0;
      r_flip_y     <= 1'b0;
      r_angle      <= ANG_RIGHT;
      r_ball_reset <= 1'b1;
      r_score_l    <= 4'd0;
      r_score_r    <= 4'd0;
      r_game_over  <= 1'b0;
      r_winner     <= 1'b0;
    end else begin
      r_ball_reset <= w_ball_reset_nxt;
      r_game_over  <= w_game_over_nxt;
`ifdef COURT_PADDLE_ANGLE_EN
      r_flip_x <= 1'b0;
      if (w_acc_l)      r_angle <= w_l_outer ? (ANG_RIGHT + 4'd1) : ANG_RIGHT;
      else if (w_acc_r) r_angle <= w_r_outer ? (ANG_LEFT - 4'd1) : ANG_LEFT;
`else
      r_flip_x <= w_acc;
`endif
      r_flip_y <= (w_acc_l && w_l_edge) || (w_acc_r && w_r_edge);

      if (w_acc)                r_hold <= HOLD_LOAD;
      else if (r_hold != 8'd0)  r_hold <= r_hold - 8'd1;

      if (r_state != ST_SERVE)  r_serve_cnt <= 8'd0;
      else if (bus.tick)        r_serve_cnt <= (r_serve_cnt == SERVE_LAST) ? 8'd0 : r_serve_cnt + 8'd1;

      if (w_miss_l) begin
        r_score_r <= w_score_r_inc;
        r_angle   <= ANG_LEFT;
        if (w_score_r_inc == WIN) r_winner <= 1'b1;
      end else if (w_miss_r) begin
        r_score_l <= w_score_l_inc;
        r_angle   <= ANG_RIGHT;
        if (w_score_l_inc == WIN) r_winner <= 1'b0;
      end
    end
  end

`ifndef COURT_PADDLE_ANGLE_EN
  logic w_zone_unused;
  assign w_zone_unused = w_l_outer ^ w_r_outer;
`endif

  assign bus.flip_x     = r_flip_x;
  assign bus.flip_y     = r_flip_y;
  assign bus.angle      = r_angle;
  assign bus.ball_reset = r_ball_reset;
  assign bus.score_l    = r_score_l;
  assign bus.score_r    = r_score_r;
  assign bus.game_over  = r_game_over;
  assign bus.winner     = r_winner;
endmodule

// File: tb/tb_court_ctrl.sv
// tb/tb_court_ctrl.sv - directed scoreboard bench for court_ctrl (either COURT_PADDLE_ANGLE_EN build).
module tb_court_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  court_ctrl_if bus();

  court_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %0d with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    bus.ball_x      = 6'd32;
    bus.ball_y      = 6'd32;
    bus.ball_radius = 4'd1;
    bus.paddle_l_y  = 6'd0;
    bus.paddle_r_y  = 6'd0;
  endtask

  task automatic serve_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    bus.tick = 1'b0;
    idle();

    push_exp("rst_ball_reset", 16'd1);
    push_exp("rst_angle", 16'd0);
    push_exp("rst_flip_x", 16'd0);
    push_exp("rst_flip_y", 16'd0);
    push_exp("rst_score_l", 16'd0);
    push_exp("rst_score_r", 16'd0);
    push_exp("rst_game_over", 16'd0);
    push_exp("rst_winner", 16'd0);
    step();
    step();
    reset = 1'b0;
    check(16'(bus.ball_reset));
    check(16'(bus.angle));
    check(16'(bus.flip_x));
    check(16'(bus.flip_y));
    check(16'(bus.score_l));
    check(16'(bus.score_r));
    check(16'(bus.game_over));
    check(16'(bus.winner));

    // serve: still held after 15 ticks, released on the 16th tick edge
    serve_ticks(15);
    push_exp("serve15_ball_reset", 16'd1);
    check(16'(bus.ball_reset));
    push_exp("serve16_ball_reset", 16'd0);
    push_exp("serve16_angle", 16'd0);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    check(16'(bus.ball_reset));
    check(16'(bus.angle));

    // left middle hit then 4 ignored repeats inside the hold window
    bus.ball_x = 6'd4; bus.ball_y = 6'd20; bus.paddle_l_y = 6'd16;
    push_exp("lhit_flip_x", 16'd1);
    push_exp("lhit_flip_y", 16'd0);
    step();
    check(16'(bus.flip_x));
    check(16'(bus.flip_y));
    for (int i = 0; i < 4; i++) begin
      push_exp("hold_flip_x", 16'd0);
      step();
      check(16'(bus.flip_x));
    end
    idle();
    push_exp("away_flip_x", 16'd0);
    step();
    check(16'(bus.flip_x));

    // left top-edge hit: both pulses together
    bus.ball_x = 6'd4; bus.ball_y = 6'd16; bus.paddle_l_y = 6'd16;
    push_exp("edge_flip_x", 16'd1);
    push_exp("edge_flip_y", 16'd1);
    step();
    check(16'(bus.flip_x));
    check(16'(bus.flip_y));
    idle();
    push_exp("edge_after_flip_x", 16'd0);
    push_exp("edge_after_flip_y", 16'd0);
    step();
    check(16'(bus.flip_x));
    check(16'(bus.flip_y));
    for (int i = 0; i < 4; i++) step();

    // left miss: right scores, ball held, serve toward left
    bus.ball_x = 6'd1; bus.ball_y = 6'd40; bus.paddle_l_y = 6'd0;
    push_exp("lmiss_score_r", 16'd1);
    push_exp("lmiss_ball_reset", 16'd1);
    push_exp("lmiss_angle", 16'd12);
    push_exp("lmiss_score_l", 16'd0);
    step();
    idle();
    check(16'(bus.score_r));
    check(16'(bus.ball_reset));
    check(16'(bus.angle));
    check(16'(bus.score_l));

    // nine right misses drive left to the winning score
    for (int k = 1; k <= 9; k++) begin
      serve_ticks(16);
      push_exp("rserve_ball_reset", 16'd0);
      check(16'(bus.ball_reset));
      bus.ball_x = 6'd62; bus.ball_y = 6'd40; bus.paddle_r_y = 6'd0;
      push_exp("rmiss_score_l", 16'(k));
      push_exp("rmiss_ball_reset", 16'd1);
      push_exp("rmiss_angle", 16'd0);
      push_exp("rmiss_game_over", (k == 9) ? 16'd1 : 16'd0);
      step();
      idle();
      check(16'(bus.score_l));
      check(16'(bus.ball_reset));
      check(16'(bus.angle));
      check(16'(bus.game_over));
    end
    push_exp("win_winner", 16'd0);
    check(16'(bus.winner));

    // OVER ignores ticks and goal crossings
    serve_ticks(16);
    bus.ball_x = 6'd1; bus.ball_y = 6'd40;
    push_exp("over_game_over", 16'd1);
    push_exp("over_ball_reset", 16'd1);
    push_exp("over_score_l", 16'd9);
    push_exp("over_score_r", 16'd1);
    step();
    step();
    idle();
    check(16'(bus.game_over));
    check(16'(bus.ball_reset));
    check(16'(bus.score_l));
    check(16'(bus.score_r));

    reset = 1'b1;
    push_exp("rst2_score_l", 16'd0);
    push_exp("rst2_score_r", 16'd0);
    push_exp("rst2_game_over", 16'd0);
    push_exp("rst2_ball_reset", 16'd1);
    step();
    reset = 1'b0;
    check(16'(bus.score_l));
    check(16'(bus.score_r));
    check(16'(bus.game_over));
    check(16'(bus.ball_reset));

    // zone behaviour: left outer-quarter hit, then right bottom-edge hit
    serve_ticks(16);
    bus.ball_x = 6'd4; bus.ball_y = 6'd17; bus.paddle_l_y = 6'd16;
`ifdef COURT_PADDLE_ANGLE_EN
    push_exp("lzone_angle", 16'd1);
    push_exp("lzone_flip_x", 16'd0);
`else
    push_exp("lzone_angle", 16'd0);
    push_exp("lzone_flip_x", 16'd1);
`endif
    push_exp("lzone_flip_y", 16'd0);
    step();
    idle();
    check(16'(bus.angle));
    check(16'(bus.flip_x));
    check(16'(bus.flip_y));
    for (int i = 0; i < 5; i++) step();

    bus.ball_x = 6'd59; bus.ball_y = 6'd23; bus.paddle_r_y = 6'd16;
`ifdef COURT_PADDLE_ANGLE_EN
    push_exp("rzone_angle", 16'd11);
    push_exp("rzone_flip_x", 16'd0);
`else
    push_exp("rzone_angle", 16'd0);
    push_exp("rzone_flip_x", 16'd1);
`endif
    push_exp("rzone_flip_y", 16'd1);
    push_exp("rzone_score_l", 16'd0);
    step();
    idle();
    check(16'(bus.angle));
    check(16'(bus.flip_x));
    check(16'(bus.flip_y));
    check(16'(bus.score_l));

    n_cmp++;
    assert (sb.size() == 0)
    else begin
      n_bad++;
      $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/court_ctrl.md
# court_ctrl

Rule engine that sits directly upstream of the ball mover on the 64×64 court. Each cycle it compares the ball position against both paddles and the goal lines, then drives the ball mover's `flip_x`, `flip_y`, `angle` and reset inputs. It also keeps the score and sequences serve, play and game-over.

## Interface
Parameters:
- `PADDLE_H`, 8, paddle height in pixels; rows `py` .. `py+PADDLE_H-1`.
- `LEFT_X`, 2, column of the left paddle face.
- `RIGHT_X`, 61, column of the right paddle face.
- `HOLD_CYCLES`, 4, clocks after a hit during which further hits are ignored.
- `SERVE_TICKS`, 16, `tick` pulses spent in SERVE.
- `WIN_SCORE`, 9, score that ends the game; legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `tick`  in  1  frame strobe; advances the serve timer.
- `ball_x`, `ball_y`  in  6 each  ball centre, integer pixels.
- `ball_radius`  in  4  ball radius in pixels.
- `paddle_l_y`, `paddle_r_y`  in  6 each  top row of each paddle.
- `flip_x`, `flip_y`  out  1 each  one-cycle reflect pulses to the ball mover.
- `angle`  out  4  direction code to the ball mover.
- `ball_reset`  out  1  holds the ball mover at centre.
- `score_l`, `score_r`  out  4 each  scores.
- `game_over`  out  1  high in OVER.
- `winner`  out  1  0 = left, 1 = right; valid while `game_over` is high.

## Operation
- States:
  - SERVE: `ball_reset`=1; counts `tick` pulses up to `SERVE_TICKS`, then goes to PLAY.
  - PLAY: `ball_reset`=0; detects hits and misses.
  - OVER: `ball_reset`=1; held until `reset`.
- Left hit, all three true:
  - `ball_x` ≤ `LEFT_X`+1+`ball_radius`;
  - `ball_y` ≥ `paddle_l_y`;
  - `ball_y` ≤ `paddle_l_y`+`PADDLE_H`-1.
- Right hit: mirrored, `ball_x` ≥ `RIGHT_X`-1-`ball_radius`.
- Compare in 8-bit unsigned arithmetic; a paddle bottom above 63 is clamped to 63.
- Edge hit: the hit row equals `paddle_y` or `paddle_y`+`PADDLE_H`-1.
- Left miss: `ball_x` ≤ `ball_radius` and no left hit. The right player scores.
- Right miss: `ball_x` ≥ 63-`ball_radius` and no right hit. The left player scores.
- A hit in PLAY with the hold counter at 0:
  - pulse `flip_x`;
  - pulse `flip_y` as well when it is an edge hit;
  - load the hold counter with `HOLD_CYCLES`. The counter decrements once per clock, saturating at 0.
- Hits while the hold counter is non-zero are ignored. Misses are still checked during the hold.
- Hit and miss true in the same cycle: the hit wins and no point is scored.
- On a miss:
  - increment the scorer's score;
  - if the new score equals `WIN_SCORE`, go to OVER and set `winner`;
  - otherwise go to SERVE with the serve counter cleared.
- Serve angle: 0 after reset; after a left miss, 12 (ball toward the left player); after a right miss, 0.
- A `reset` in any state restores all reset values on the next edge.

## Timing
- Reset values:
  - state SERVE, `ball_reset`=1, `angle`=0;
  - `flip_x`=0, `flip_y`=0;
  - scores 0, `game_over`=0, `winner`=0;
  - hold counter 0, serve counter 0.
- All outputs are registered. A condition sampled in cycle N is visible after edge N+1.
- `flip_x` and `flip_y` are high for exactly one cycle per accepted hit.
- `ball_reset` rises in the cycle after the miss was sampled, and in that same cycle the score is updated.
- SERVE → PLAY happens on the clock edge at which the `SERVE_TICKS`-th `tick` is sampled.
- `tick` is ignored outside SERVE.

## Configuration
- Macro: `COURT_PADDLE_ANGLE_EN`.
- Defined — on an accepted hit `flip_x` is not pulsed; `angle` is loaded instead:
  - left paddle: 0 for a middle-half hit, 1 for an outer-quarter hit;
  - right paddle: 12 for a middle-half hit, 11 for an outer-quarter hit;
  - `flip_y` behaves as in the base design.
- Undefined: `angle` changes only at serve, and `flip_x` is pulsed on every accepted hit.

## Structure
- Shared package `pong_pkg` holds:
  - court size constant 64;
  - angle constants `ANG_RIGHT`=0 and `ANG_LEFT`=12;
  - the state encoding (SERVE, PLAY, OVER).
- Sub-module `paddle_hit`: combinational hit, edge and zone compare. Instantiated twice, once per paddle, with the face column as a parameter.

## Test plan
- Reset, then 16 `tick` pulses: `ball_reset` 1→0 on the 16th tick edge; `angle`=0.
- `ball_x`=4, `ball_radius`=1, `ball_y`=20, `paddle_l_y`=16: one `flip_x` pulse; a repeat in the next 4 cycles gives no pulse.
- `ball_y`=16, `paddle_l_y`=16, in hit range: `flip_x` and `flip_y` pulse in the same cycle.
- `ball_x`=1, `ball_radius`=1, `ball_y`=40, `paddle_l_y`=0: `score_r`=1, `ball_reset`=1, `angle`=12.
- Nine right misses: `score_l`=9, `game_over`=1, `winner`=0; stays in OVER until `reset`, which clears both scores.
- With `COURT_PADDLE_ANGLE_EN`, left hit at row `paddle_l_y`+1: `angle`=1, no `flip_x` pulse.
